cdb_arbiter: RTL

//  Registered arbiter that shares the single common data bus between NUM_SRC result producers (src 0 = ALU, src 1 = mem/d_cache).

---
 rtl/cdb_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result FIFOs drained one entry per cycle,
// granted round-robin and broadcast from registered outputs.
module cdb_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int ROB_W      = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
  input  logic [NUM_SRC*ROB_W-1:0]        src_rob_id,
  output logic                            cdb_valid,
  output logic [TAG_WIDTH-1:0]            cdb_tag,
  output logic [DATA_WIDTH-1:0]           cdb_data,
  output logic [ROB_W-1:0]                cdb_rob_id,
  output logic [$clog2(NUM_SRC)-1:0]      cdb_src,
  output logic [31:0]                     conflict_cnt
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic [ROB_W-1:0]      rob_id;
  } entry_t;

  entry_t           mem_q    [NUM_SRC][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_d [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_d [NUM_SRC];
  logic [CNT_W-1:0] count_q  [NUM_SRC];
  logic [CNT_W-1:0] count_d  [NUM_SRC];

  logic [NUM_SRC-1:0] push, pop, nonempty;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d, grant_idx, cand;
  logic               grant_vld;
  entry_t             head;

  logic               cdb_valid_q, cdb_valid_d;
  entry_t             cdb_q, cdb_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;
  logic [31:0]        conflict_cnt_q, conflict_cnt_d;

  // Ready depends only on occupancy, so a full FIFO refuses a push even while it pops.
  always_comb begin
    src_ready = '0;
    nonempty  = '0;
    push      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count_q[i] != CNT_W'(DEPTH));
      nonempty[i]  = (count_q[i] != '0);
      push[i]      = src_valid[i] & src_ready[i] & ~flush;
    end
  end

  // NOTE: every variable gets a default before any conditional update; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    pop = '0;
    if (grant_vld) pop[grant_idx] = 1'b1;
    head = mem_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + 1'b1 : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + 1'b1 : rd_ptr_q[i];
      if (flush) begin
        count_d[i]  = '0;
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end
    end
    cdb_valid_d = grant_vld & ~flush;
    cdb_d       = cdb_valid_d ? head      : cdb_q;
    cdb_src_d   = cdb_valid_d ? grant_idx : cdb_src_q;
    rr_ptr_d    = cdb_valid_d ? grant_idx : rr_ptr_q;
    conflict_cnt_d = conflict_cnt_q;
    if (($countones(nonempty) >= 2) && (conflict_cnt_q != 32'hFFFF_FFFF))
      conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  // NOTE: payload storage carries no reset; occupancy counters alone decide
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= '{tag:    src_tag[i*TAG_WIDTH +: TAG_WIDTH],
                                   data:   src_data[i*DATA_WIDTH +: DATA_WIDTH],
                                   rob_id: src_rob_id[i*ROB_W +: ROB_W]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q       <= SRC_W'(NUM_SRC - 1);
      cdb_valid_q    <= 1'b0;
      cdb_q          <= '0;
      cdb_src_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_q          <= cdb_d;
      cdb_src_q      <= cdb_src_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_q.tag;
  assign cdb_data     = cdb_q.data;
  assign cdb_rob_id   = cdb_q.rob_id;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
